frv_bitwise_wb: RTL and testbench

Writeback sequencer on the consumer side of the bitwise functional unit. It accepts 32-bit and 64-bit bitwise results (funnel shifts, cmov, lut, bop: 32-bit; mror: 64-bit) over a valid/ready handshake and buffers them in a small FIFO. Each result is turned into one or two GPR write requests on a single register-file write port, arbitrated by an ack. It also exports a pending-write mask that issue logic uses for RAW stalls.

---
 rtl/frv_bitwise_wb.sv | 154 +++++++++++++++
 tb/tb_frv_bitwise_wb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/frv_bitwise_wb.sv
// Writeback sequencer for the bitwise unit: buffers 32/64-bit results in a small FIFO
// and turns each into one or two GPR writes on a single acked register-file port.
module frv_bitwise_wb #(
    parameter int DEPTH = 2
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        flush,
    input  logic        fu_valid,
    output logic        fu_ready,
    input  logic [63:0] fu_result,
    input  logic        fu_wide,
    input  logic [4:0]  fu_rd,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic        rf_ack,
    output logic [31:0] pending,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0]  PH_LO   = 1'b0;
    localparam logic [0:0]  PH_HI   = 1'b1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [63:0]      res_mem_r [DEPTH];
    logic [4:0]       rd_mem_r  [DEPTH];
    logic [DEPTH-1:0] wide_mem_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW:0]      count_r;
    logic [0:0]       phase_r;

    logic        head_valid_s;
    logic        push_s;
    logic        pop_s;
    logic        to_hi_s;
    logic [63:0] head_res_s;
    logic [4:0]  head_rd_s;
    logic        head_wide_s;
    logic [31:0] pending_s;

    // Accept side and head entry fetch
    always_comb begin
        fu_ready     = !g_reset && !flush && (count_r < CNT_FULL);
        push_s       = fu_valid && fu_ready;
        head_valid_s = (count_r != CNT_ZERO);
        busy         = head_valid_s;
        head_res_s   = res_mem_r[rd_ptr_r];
        head_rd_s    = rd_mem_r[rd_ptr_r];
        head_wide_s  = wide_mem_r[rd_ptr_r];
    end

    // Head write request; narrow writes to x0 retire without using the port
    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        pop_s    = 1'b0;
        to_hi_s  = 1'b0;
        if (head_valid_s) begin
            if (phase_r == PH_HI) begin
                rf_wen   = 1'b1;
                rf_waddr = {head_rd_s[4:1], 1'b1};
                rf_wdata = head_res_s[63:32];
                pop_s    = rf_ack;
            end else if (head_wide_s) begin
                rf_wen   = 1'b1;
                rf_waddr = {head_rd_s[4:1], 1'b0};
                rf_wdata = head_res_s[31:0];
                to_hi_s  = rf_ack;
            end else if (head_rd_s != 5'd0) begin
                rf_wen   = 1'b1;
                rf_waddr = head_rd_s;
                rf_wdata = head_res_s[31:0];
                pop_s    = rf_ack;
            end else begin
                pop_s    = 1'b1;
            end
        end else begin
            rf_wen   = 1'b0;
        end
    end

    // Pending mask over live entries; a head already in HI only still owes rd_hi
    always_comb begin
        logic [AW-1:0] idx;
        idx       = PTR_ZERO;
        pending_s = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_r + AW'(k);
            if ((AW+1)'(k) < count_r) begin
                if ((idx == rd_ptr_r) && (phase_r == PH_HI)) begin
                    pending_s[{rd_mem_r[idx][4:1], 1'b1}] = 1'b1;
                end else if (wide_mem_r[idx]) begin
                    pending_s[{rd_mem_r[idx][4:1], 1'b0}] = 1'b1;
                    pending_s[{rd_mem_r[idx][4:1], 1'b1}] = 1'b1;
                end else begin
                    pending_s[rd_mem_r[idx]] = 1'b1;
                end
            end else begin
                pending_s = pending_s;
            end
        end
        pending = {pending_s[31:1], 1'b0};
    end

    // FIFO storage; no reset needed since count gates validity
    always_ff @(posedge g_clk) begin
        if (push_s) begin
            res_mem_r[wr_ptr_r]  <= fu_result;
            rd_mem_r[wr_ptr_r]   <= fu_rd;
            wide_mem_r[wr_ptr_r] <= fu_wide;
        end
    end

    // Pointers, occupancy and head phase
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            phase_r  <= PH_LO;
        end else if (flush) begin
            if ((phase_r == PH_HI) && head_valid_s && !rf_ack) begin
                // keep only the half-written head so the pair completes
                count_r  <= CNT_ONE;
                wr_ptr_r <= rd_ptr_r + PTR_ONE;
                phase_r  <= PH_HI;
            end else begin
                count_r  <= CNT_ZERO;
                wr_ptr_r <= rd_ptr_r;
                phase_r  <= PH_LO;
            end
        end else begin
            rd_ptr_r <= rd_ptr_r + (pop_s ? PTR_ONE : PTR_ZERO);
            wr_ptr_r <= wr_ptr_r + (push_s ? PTR_ONE : PTR_ZERO);
            count_r  <= count_r + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
            if (pop_s) begin
                phase_r <= PH_LO;
            end else if (to_hi_s) begin
                phase_r <= PH_HI;
            end else begin
                phase_r <= phase_r;
            end
        end
    end

endmodule

// File: tb/tb_frv_bitwise_wb.sv
// Randomized bench for frv_bitwise_wb: a queue-based model of the writeback rules is
// compared every cycle, plus directed scenarios with literal expectations.
module tb_frv_bitwise_wb;

    localparam int DEPTH = 2;

    logic        g_clk = 1'b0;
    logic        g_reset, flush, fu_valid, fu_ready, fu_wide;
    logic [63:0] fu_result;
    logic [4:0]  fu_rd, rf_waddr;
    logic        rf_wen, rf_ack, busy;
    logic [31:0] rf_wdata, pending;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] res;
        bit          wide;
        int          rd;
    } entry_t;

    entry_t mq[$];
    bit     m_half = 1'b0;

    frv_bitwise_wb #(.DEPTH(DEPTH)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_result(fu_result),
        .fu_wide(fu_wide), .fu_rd(fu_rd),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ack(rf_ack),
        .pending(pending), .busy(busy)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model, then advance the model by one clock.
    task automatic step();
        bit          e_ready, e_wen, do_push;
        int          e_addr;
        logic [31:0] e_data, e_pend;
        @(negedge g_clk);
        e_ready = !g_reset && !flush && (mq.size() < DEPTH);
        e_wen = 1'b0; e_addr = 0; e_data = 32'd0; e_pend = 32'd0;
        if (mq.size() > 0) begin
            if (m_half) begin
                e_wen = 1'b1; e_addr = mq[0].rd | 1; e_data = mq[0].res[63:32];
            end else if (mq[0].wide) begin
                e_wen = 1'b1; e_addr = mq[0].rd & 30; e_data = mq[0].res[31:0];
            end else if (mq[0].rd != 0) begin
                e_wen = 1'b1; e_addr = mq[0].rd; e_data = mq[0].res[31:0];
            end
        end
        foreach (mq[i]) begin
            if (i == 0 && m_half) e_pend |= 32'd1 << (mq[i].rd | 1);
            else if (mq[i].wide) e_pend |= 32'd3 << (mq[i].rd & 30);
            else e_pend |= 32'd1 << mq[i].rd;
        end
        e_pend &= 32'hFFFF_FFFE;
        chk("fu_ready", 64'(fu_ready), 64'(e_ready));
        chk("rf_wen", 64'(rf_wen), 64'(e_wen));
        chk("busy", 64'(busy), 64'(mq.size() != 0));
        chk("pending", 64'(pending), 64'(e_pend));
        if (e_wen) begin
            chk("rf_waddr", 64'(rf_waddr), 64'(e_addr));
            chk("rf_wdata", 64'(rf_wdata), 64'(e_data));
        end
        do_push = fu_valid && e_ready;
        if (g_reset) begin
            mq.delete(); m_half = 1'b0;
        end else if (flush) begin
            if (m_half && !rf_ack) begin
                while (mq.size() > 1) void'(mq.pop_back());
            end else begin
                mq.delete(); m_half = 1'b0;
            end
        end else begin
            if (mq.size() > 0) begin
                if (m_half) begin
                    if (rf_ack) begin void'(mq.pop_front()); m_half = 1'b0; end
                end else if (mq[0].wide) begin
                    if (rf_ack) m_half = 1'b1;
                end else if (mq[0].rd == 0 || rf_ack) begin
                    void'(mq.pop_front());
                end
            end
            if (do_push) mq.push_back('{res: fu_result, wide: fu_wide, rd: int'(fu_rd)});
        end
        @(posedge g_clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [63:0] r, input bit w, input int rd);
        fu_valid = v; fu_result = r; fu_wide = w; fu_rd = 5'(rd);
    endtask

    initial begin
        g_reset = 1'b1; flush = 1'b0; rf_ack = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 0);
        #1;
        step(); step();
        chk("rst_ready", 64'(fu_ready), 64'd0);
        chk("rst_wen", 64'(rf_wen), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        g_reset = 1'b0; #1;
        chk("ready_after_rst", 64'(fu_ready), 64'd1);

        // narrow write to x5
        rf_ack = 1'b1; drive(1'b1, 64'h0000_0000_DEAD_BEEF, 1'b0, 5); step();
        drive(1'b0, 64'd0, 1'b0, 0); #1;
        chk("nar_addr", 64'(rf_waddr), 64'd5);
        chk("nar_data", 64'(rf_wdata), 64'hDEADBEEF);
        chk("nar_pend", 64'(pending), 64'h20);
        step();
        chk("nar_done", 64'(busy), 64'd0);

        // wide write to pair 6/7
        drive(1'b1, 64'h1111_2222_3333_4444, 1'b1, 7); step();
        drive(1'b0, 64'd0, 1'b0, 0); #1;
        chk("wide_lo_addr", 64'(rf_waddr), 64'd6);
        chk("wide_lo_data", 64'(rf_wdata), 64'h33334444);
        chk("wide_lo_pend", 64'(pending), 64'hC0);
        step();
        chk("wide_hi_addr", 64'(rf_waddr), 64'd7);
        chk("wide_hi_data", 64'(rf_wdata), 64'h11112222);
        chk("wide_hi_pend", 64'(pending), 64'h80);
        step();
        chk("wide_done", 64'(busy), 64'd0);

        // narrow x0 retires with no write; wide rd=1 writes x0 then x1
        drive(1'b1, 64'h55, 1'b0, 0); step();
        drive(1'b0, 64'd0, 1'b0, 0); #1;
        chk("x0_wen", 64'(rf_wen), 64'd0);
        chk("x0_pend", 64'(pending), 64'd0);
        step();
        chk("x0_done", 64'(busy), 64'd0);
        drive(1'b1, 64'hAAAA_0001_BBBB_0000, 1'b1, 1); step();
        drive(1'b0, 64'd0, 1'b0, 0); #1;
        chk("x0w_addr", 64'(rf_waddr), 64'd0);
        step(); step();

        // backpressure: three back-to-back pushes into two slots
        rf_ack = 1'b0;
        drive(1'b1, 64'h31, 1'b0, 3); step();
        drive(1'b1, 64'h41, 1'b0, 4); step();
        drive(1'b1, 64'h51, 1'b0, 5); #1;
        chk("bp_full", 64'(fu_ready), 64'd0);
        chk("bp_head", 64'(rf_waddr), 64'd3);
        step(); step();
        rf_ack = 1'b1;
        for (int i = 0; i < 4; i++) step();
        drive(1'b0, 64'd0, 1'b0, 0);
        for (int i = 0; i < 3; i++) step();

        // flush with head in HI keeps the pair, drops the queued narrow
        rf_ack = 1'b0;
        drive(1'b1, 64'h9999_0000_8888_0000, 1'b1, 9); step();
        drive(1'b1, 64'hC, 1'b0, 12); step();
        drive(1'b0, 64'd0, 1'b0, 0); rf_ack = 1'b1; step();
        rf_ack = 1'b0; #1;
        chk("fl_pend_pre", 64'(pending), 64'h1200);
        flush = 1'b1; step();
        flush = 1'b0; #1;
        chk("fl_pend_post", 64'(pending), 64'h200);
        chk("fl_hi_addr", 64'(rf_waddr), 64'd9);
        rf_ack = 1'b1; step();
        chk("fl_done", 64'(busy), 64'd0);

        // flush with head in LO clears everything
        rf_ack = 1'b0;
        drive(1'b1, 64'hA, 1'b0, 10); step();
        drive(1'b0, 64'd0, 1'b0, 0); flush = 1'b1; step();
        flush = 1'b0; #1;
        chk("fllo_wen", 64'(rf_wen), 64'd0);
        chk("fllo_busy", 64'(busy), 64'd0);

        // reset in the middle of a pair
        rf_ack = 1'b1;
        drive(1'b1, 64'h2, 1'b1, 20); step();
        drive(1'b0, 64'd0, 1'b0, 0); step();
        rf_ack = 1'b0; #1;
        chk("rp_hi_addr", 64'(rf_waddr), 64'd21);
        g_reset = 1'b1; step();
        chk("rp_wen", 64'(rf_wen), 64'd0);
        chk("rp_pend", 64'(pending), 64'd0);
        g_reset = 1'b0; #1;
        chk("rp_ready", 64'(fu_ready), 64'd1);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            drive(1'($urandom_range(0, 1)), {$urandom(), $urandom()},
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
            rf_ack  = ($urandom_range(0, 9) < 6);
            flush   = ($urandom_range(0, 39) == 0);
            g_reset = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
